// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raster_pkg
// Brief    : Shared raster types, screen defaults and min/max helpers.
// Revision : 1.0
// ============================================================================
package raster_pkg;

    localparam int COORD_W  = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } tri_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2
    } scan_state_t;

    function automatic logic signed [COORD_W-1:0] smin3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] smax3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_setup.sv
`default_nettype none
// ============================================================================
// Module   : bbox_setup
// Brief    : Combinational screen-clipped bounding box and zero-area reject.
// Revision : 1.0
// ============================================================================
module bbox_setup
    import raster_pkg::*;
#(
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  tri_t                      tri_in,
    output logic signed [COORD_W-1:0] xmin,
    output logic signed [COORD_W-1:0] xmax,
    output logic signed [COORD_W-1:0] ymin,
    output logic signed [COORD_W-1:0] ymax,
    output logic                      reject
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * DW;
    localparam int AW = PW + 1;

    localparam logic signed [COORD_W-1:0] c_xlim = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] c_ylim = COORD_W'(SCREEN_H - 1);

    logic signed [COORD_W-1:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
    logic signed [COORD_W-1:0] w_minx, w_maxx, w_miny, w_maxy;
    logic signed [DW-1:0]      w_dx1, w_dy1, w_dx2, w_dy2;
    logic signed [PW-1:0]      w_p1, w_p2;
    logic signed [AW-1:0]      w_area2;

    assign w_x0 = tri_in.v0.x;
    assign w_y0 = tri_in.v0.y;
    assign w_x1 = tri_in.v1.x;
    assign w_y1 = tri_in.v1.y;
    assign w_x2 = tri_in.v2.x;
    assign w_y2 = tri_in.v2.y;

    assign w_minx = smin3(w_x0, w_x1, w_x2);
    assign w_maxx = smax3(w_x0, w_x1, w_x2);
    assign w_miny = smin3(w_y0, w_y1, w_y2);
    assign w_maxy = smax3(w_y0, w_y1, w_y2);

    // A negative minimum clamps to the screen origin.
    assign xmin = w_minx[COORD_W-1] ? '0 : w_minx;
    assign ymin = w_miny[COORD_W-1] ? '0 : w_miny;
    assign xmax = (w_maxx > c_xlim) ? c_xlim : w_maxx;
    assign ymax = (w_maxy > c_ylim) ? c_ylim : w_maxy;

    // Edge differences are sign-extended one bit so no vertex pair can overflow.
    assign w_dx1 = {w_x1[COORD_W-1], w_x1} - {w_x0[COORD_W-1], w_x0};
    assign w_dy1 = {w_y1[COORD_W-1], w_y1} - {w_y0[COORD_W-1], w_y0};
    assign w_dx2 = {w_x2[COORD_W-1], w_x2} - {w_x0[COORD_W-1], w_x0};
    assign w_dy2 = {w_y2[COORD_W-1], w_y2} - {w_y0[COORD_W-1], w_y0};

    assign w_p1    = PW'(w_dx1) * PW'(w_dy2);
    assign w_p2    = PW'(w_dx2) * PW'(w_dy1);
    assign w_area2 = AW'(w_p1) - AW'(w_p2);

    assign reject = (w_area2 == '0) || (xmin > xmax) || (ymin > ymax);

endmodule
`default_nettype wire

// File: rtl/bbox_scan.sv
`default_nettype none
// ============================================================================
// Module   : bbox_scan
// Brief    : Accepts a triangle and streams its clipped bbox pixels row-major.
// Revision : 1.0
// ============================================================================
module bbox_scan
    import raster_pkg::*;
#(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] in_x0,
    input  logic signed [COORD_W-1:0] in_y0,
    input  logic signed [COORD_W-1:0] in_x1,
    input  logic signed [COORD_W-1:0] in_y1,
    input  logic signed [COORD_W-1:0] in_x2,
    input  logic signed [COORD_W-1:0] in_y2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_px,
    output logic signed [COORD_W-1:0] out_py,
    output logic signed [COORD_W-1:0] out_x0,
    output logic signed [COORD_W-1:0] out_y0,
    output logic signed [COORD_W-1:0] out_x1,
    output logic signed [COORD_W-1:0] out_y1,
    output logic signed [COORD_W-1:0] out_x2,
    output logic signed [COORD_W-1:0] out_y2,
    output logic                      out_last,
    output logic                      tri_done,
    output logic                      tri_skipped,
    output logic                      busy
);

    scan_state_t               r_state, w_state_next;
    tri_t                      r_tri;
    logic signed [COORD_W-1:0] r_px, r_py, r_xmin, r_xmax, r_ymax;
    logic                      r_done, r_skip;
    logic signed [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic                      w_reject;
    logic                      w_at_last;

    bbox_setup #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_setup (
        .tri_in (r_tri),
        .xmin   (w_xmin),
        .xmax   (w_xmax),
        .ymin   (w_ymin),
        .ymax   (w_ymax),
        .reject (w_reject)
    );

    assign w_at_last = (r_px == r_xmax) && (r_py == r_ymax);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = SETUP;
            end
            SETUP: begin
                w_state_next = w_reject ? IDLE : SCAN;
            end
            SCAN: begin
                out_valid = 1'b1;
                out_last  = w_at_last;
                if (out_ready && w_at_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tri   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_done  <= 1'b0;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            r_skip  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) r_tri <= {in_x0, in_y0, in_x1, in_y1, in_x2, in_y2};
                end
                SETUP: begin
                    if (w_reject) begin
                        r_done <= 1'b1;
                        r_skip <= 1'b1;
                    end else begin
                        r_px   <= w_xmin;
                        r_py   <= w_ymin;
                        r_xmin <= w_xmin;
                        r_xmax <= w_xmax;
                        r_ymax <= w_ymax;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (w_at_last) begin
                            r_done <= 1'b1;
                        end else if (r_px < r_xmax) begin
                            r_px <= r_px + COORD_W'(1);
                        end else begin
                            r_px <= r_xmin;
                            r_py <= r_py + COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_px      = r_px;
    assign out_py      = r_py;
    assign out_x0      = r_tri.v0.x;
    assign out_y0      = r_tri.v0.y;
    assign out_x1      = r_tri.v1.x;
    assign out_y1      = r_tri.v1.y;
    assign out_x2      = r_tri.v2.x;
    assign out_y2      = r_tri.v2.y;
    assign tri_done    = r_done;
    assign tri_skipped = r_skip;

endmodule
`default_nettype wire
